// File: rtl/dcache_tag_status_request_q_if.sv
// Bus bundle between the cache controller and its coherence bookkeeping storage:
// tag store, status store and snoop request FIFO signals.
interface dcache_tag_status_request_q_if #(
  parameter int TAG_W  = 21,
  parameter int STAT_W = 2,
  parameter int LINES  = 128
);
  localparam int IDX_W = $clog2(LINES);

  logic [IDX_W-1:0]  tag_a;
  logic [TAG_W-1:0]  tag_d;
  logic              tag_we;
  logic [IDX_W-1:0]  tag_dpra;
  logic [TAG_W-1:0]  tag_spo;
  logic [TAG_W-1:0]  tag_dpo;

  logic [IDX_W-1:0]  stat_a;
  logic [STAT_W-1:0] stat_d;
  logic              stat_we;
  logic [IDX_W-1:0]  stat_dpra;
  logic [STAT_W-1:0] stat_spo;
  logic [STAT_W-1:0] stat_dpo;

  logic [31:0]       q_din;
  logic              q_wr_en;
  logic              q_rd_en;
  logic [31:0]       q_dout;
  logic              q_full;
  logic              q_empty;
  logic              q_almost_empty;

  modport master (
    output tag_a, tag_d, tag_we, tag_dpra,
    input  tag_spo, tag_dpo,
    output stat_a, stat_d, stat_we, stat_dpra,
    input  stat_spo, stat_dpo,
    output q_din, q_wr_en, q_rd_en,
    input  q_dout, q_full, q_empty, q_almost_empty
  );

  modport slave (
    input  tag_a, tag_d, tag_we, tag_dpra,
    output tag_spo, tag_dpo,
    input  stat_a, stat_d, stat_we, stat_dpra,
    output stat_spo, stat_dpo,
    input  q_din, q_wr_en, q_rd_en,
    output q_dout, q_full, q_empty, q_almost_empty
  );
endinterface

// File: rtl/dcache_tag_status_request_q.sv
// Coherence bookkeeping storage: dual-read tag and status RAMs plus a
// first-word-fall-through snoop request FIFO. Pure storage, no policy.
module dcache_tag_status_request_q #(
  parameter int TAG_W   = 21,
  parameter int STAT_W  = 2,
  parameter int LINES   = 128,
  parameter int Q_DEPTH = 16
) (
  input logic                          clock,
  input logic                          reset,
  dcache_tag_status_request_q_if.slave bus
);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Stores come up all-zero (tag 0, status INVALID); reset leaves them alone.
  logic [TAG_W-1:0]  tag_mem  [LINES] = '{default: '0};
  logic [STAT_W-1:0] stat_mem [LINES] = '{default: '0};

  always_ff @(posedge clock) begin
    if (bus.tag_we)
      tag_mem[bus.tag_a] <= bus.tag_d;
  end

  always_ff @(posedge clock) begin
    if (bus.stat_we)
      stat_mem[bus.stat_a] <= bus.stat_d;
  end

  assign bus.tag_spo  = tag_mem[bus.tag_a];
  assign bus.tag_dpo  = tag_mem[bus.tag_dpra];
  assign bus.stat_spo = stat_mem[bus.stat_a];
  assign bus.stat_dpo = stat_mem[bus.stat_dpra];

  logic [31:0]      fifo_mem [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             empty;
  logic             almost_empty;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // A push on a full FIFO is dropped even if a pop frees a slot this cycle.
  always_comb begin
    push_ok    = bus.q_wr_en && !full && !reset;
    pop_ok     = bus.q_rd_en && !empty;
    count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= bus.q_din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count        <= count_next;
      empty        <= (count_next == '0);
      almost_empty <= (count_next <= CNT_W'(1));
      full         <= (count_next == CNT_W'(Q_DEPTH));
    end
  end

  // Masking the head while empty keeps stale words invisible after reset.
  assign bus.q_dout         = empty ? '0 : fifo_mem[rd_ptr];
  assign bus.q_empty        = empty;
  assign bus.q_almost_empty = almost_empty;
  assign bus.q_full         = full;
endmodule

// File: tb/tb_dcache_tag_status_request_q.sv
// Directed bench for the tag/status stores and snoop request FIFO; FIFO
// words are checked by a monitor against a queue of expected pops.
module tb_dcache_tag_status_request_q;
  logic clock = 1'b0;
  logic reset = 1'b1;

  dcache_tag_status_request_q_if bus ();

  dcache_tag_status_request_q dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT actually performs must match the scoreboard head.
  always @(negedge clock) begin
    if (!reset && bus.q_rd_en && !bus.q_empty) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %h expected no word", bus.q_dout);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        check("pop_data", bus.q_dout, exp);
      end
    end
  end

  task automatic cycle(input logic wr, input logic [31:0] din, input logic rd, input logic accept);
    if (wr && accept) sb.push_back(din);
    bus.q_wr_en = wr;
    bus.q_din   = din;
    bus.q_rd_en = rd;
    @(posedge clock);
    #1;
    bus.q_wr_en = 1'b0;
    bus.q_rd_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] din, input logic accept);
    cycle(1'b1, din, 1'b0, accept);
  endtask

  task automatic pop();
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic flags(input string name, input logic e, input logic ae, input logic f);
    check({name, "_empty"}, 32'(bus.q_empty), 32'(e));
    check({name, "_almost_empty"}, 32'(bus.q_almost_empty), 32'(ae));
    check({name, "_full"}, 32'(bus.q_full), 32'(f));
  endtask

  task automatic pulse_reset(input logic wr, input logic [31:0] din);
    reset = 1'b1;
    bus.q_wr_en = wr;
    bus.q_din   = din;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.q_wr_en = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tag_a = '0; bus.tag_d = '0; bus.tag_we = 1'b0; bus.tag_dpra = '0;
    bus.stat_a = '0; bus.stat_d = '0; bus.stat_we = 1'b0; bus.stat_dpra = '0;
    bus.q_din = '0; bus.q_wr_en = 1'b0; bus.q_rd_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    flags("reset", 1'b1, 1'b1, 1'b0);
    check("reset_dout", bus.q_dout, 32'h0);

    // Tag store read-during-write and second read port
    bus.tag_a = 7'd5; bus.tag_d = 21'h1ABCD; bus.tag_we = 1'b1; bus.tag_dpra = 7'd5;
    #1;
    check("tag_spo_before", 32'(bus.tag_spo), 32'h0);
    check("tag_dpo_before", 32'(bus.tag_dpo), 32'h0);
    @(posedge clock);
    #1;
    bus.tag_we = 1'b0;
    check("tag_spo_after", 32'(bus.tag_spo), 32'h1ABCD);
    check("tag_dpo_after", 32'(bus.tag_dpo), 32'h1ABCD);
    bus.tag_dpra = 7'd6;
    #1;
    check("tag_dpo_idx6", 32'(bus.tag_dpo), 32'h0);

    // Status store at both ends of the index range, surviving reset
    bus.stat_a = 7'd127; bus.stat_d = 2'd3; bus.stat_we = 1'b1;
    @(posedge clock);
    #1;
    bus.stat_a = 7'd0; bus.stat_d = 2'd1;
    @(posedge clock);
    #1;
    bus.stat_we = 1'b0;
    bus.stat_a = 7'd127; bus.stat_dpra = 7'd0;
    #1;
    check("stat_spo_127", 32'(bus.stat_spo), 32'd3);
    check("stat_dpo_0", 32'(bus.stat_dpo), 32'd1);
    pulse_reset(1'b0, 32'h0);
    pulse_reset(1'b0, 32'h0);
    bus.stat_a = 7'd0; bus.stat_dpra = 7'd127;
    #1;
    check("stat_spo_0_rst", 32'(bus.stat_spo), 32'd1);
    check("stat_dpo_127_rst", 32'(bus.stat_dpo), 32'd3);
    check("tag_spo_rst", 32'(bus.tag_spo), 32'h1ABCD);

    // Fill to full, drop overflow, drain in order
    for (int i = 1; i <= 16; i++) begin
      push(32'h1000_0000 + 32'(i), 1'b1);
      if (i == 1)  flags("fill1", 1'b0, 1'b1, 1'b0);
      if (i == 15) flags("fill15", 1'b0, 1'b0, 1'b0);
    end
    flags("fill16", 1'b0, 1'b0, 1'b1);
    check("full_head", bus.q_dout, 32'h1000_0001);
    push(32'h0000_DEAD, 1'b0);
    flags("overflow", 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      pop();
      if (i == 15) flags("drain15", 1'b0, 1'b1, 1'b0);
    end
    flags("drained", 1'b1, 1'b1, 1'b0);
    check("drained_dout", bus.q_dout, 32'h0);
    pop();
    flags("underflow", 1'b1, 1'b1, 1'b0);

    // Fall-through and almost_empty
    push(32'hA000_00A1, 1'b1);
    check("fwft_dout", bus.q_dout, 32'hA000_00A1);
    flags("fwft1", 1'b0, 1'b1, 1'b0);
    push(32'hA000_00A2, 1'b1);
    flags("fwft2", 1'b0, 1'b0, 1'b0);
    pop();
    check("fwft_next", bus.q_dout, 32'hA000_00A2);
    pop();
    flags("fwft_done", 1'b1, 1'b1, 1'b0);

    // Push+pop on empty: pop ignored, push taken
    cycle(1'b1, 32'hB000_00B1, 1'b1, 1'b1);
    flags("pp_empty", 1'b0, 1'b1, 1'b0);
    check("pp_empty_dout", bus.q_dout, 32'hB000_00B1);
    pop();
    flags("pp_empty_done", 1'b1, 1'b1, 1'b0);

    // Push+pop on full: push dropped, count falls to 15
    for (int i = 0; i < 16; i++) push(32'hC000_0000 + 32'(i), 1'b1);
    cycle(1'b1, 32'h0000_0BAD, 1'b1, 1'b0);
    flags("pp_full", 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      pop();
      if (i == 14) flags("pp_full14", 1'b0, 1'b1, 1'b0);
    end
    flags("pp_full_done", 1'b1, 1'b1, 1'b0);

    // Push+pop with 3 words: count stays 3
    for (int i = 1; i <= 3; i++) push(32'hD000_0000 + 32'(i), 1'b1);
    cycle(1'b1, 32'hD000_0004, 1'b1, 1'b1);
    flags("pp_mid", 1'b0, 1'b0, 1'b0);
    check("pp_mid_head", bus.q_dout, 32'hD000_0002);
    repeat (3) pop();
    flags("pp_mid_done", 1'b1, 1'b1, 1'b0);

    // Streaming across pointer wrap
    for (int i = 0; i < 40; i++)
      cycle(1'b1, 32'hE000_0000 + 32'(i), (i >= 2), 1'b1);
    flags("stream", 1'b0, 1'b0, 1'b0);
    repeat (2) pop();
    flags("stream_done", 1'b1, 1'b1, 1'b0);

    // Reset with words queued and a coincident push
    for (int i = 1; i <= 5; i++) push(32'hF000_0000 + 32'(i), 1'b1);
    pulse_reset(1'b1, 32'h0000_0077);
    flags("midreset", 1'b1, 1'b1, 1'b0);
    check("midreset_dout", bus.q_dout, 32'h0);
    push(32'h0000_0099, 1'b1);
    check("post_reset_head", bus.q_dout, 32'h0000_0099);
    flags("post_reset", 1'b0, 1'b1, 1'b0);
    pop();
    flags("post_reset_done", 1'b1, 1'b1, 1'b0);

    repeat (2) @(posedge clock);
    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
